// File: rtl/task_manager_pkg.sv
// Shared types and widths for the host-side task manager.
// Imported by the task interfaces, the byte buffer and the task_manager top.
package task_manager_pkg;

  localparam int TASK_BYTE_W = 8;
  localparam int TASK_WORD_W = 32;
  localparam int TASK_SIZE_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_ANS,
    ST_RECV,
    ST_DONE
  } tm_state_t;

  // Number of 32-bit words needed for a byte count; 13 bits so 4095+3 cannot wrap.
  function automatic logic [12:0] ceil_words(input logic [TASK_SIZE_W-1:0] size);
    return ({1'b0, size} + 13'd3) >> 2;
  endfunction

endpackage

// File: rtl/task_interfaces.sv
// Byte stream into a task and word stream back out of it.
// The task manager owns the master ends; task blocks own the slave ends.
interface task_in_interface;
  logic [task_manager_pkg::TASK_BYTE_W-1:0] task_data;
  logic                                     task_data_valid;
  logic                                     task_data_last;
  logic                                     task_data_request;

  modport master (output task_data, task_data_valid, task_data_last,
                  input  task_data_request);
  modport slave  (input  task_data, task_data_valid, task_data_last,
                  output task_data_request);
endinterface

interface task_out_interface;
  logic                                     task_manager_ready;
  logic                                     task_answer_ready;
  logic [task_manager_pkg::TASK_WORD_W-1:0] task_answer_data;
  logic                                     task_answer_data_last;
  logic [task_manager_pkg::TASK_SIZE_W-1:0] task_answer_packet_size_in_bytes;

  modport master (output task_manager_ready,
                  input  task_answer_ready, task_answer_data, task_answer_data_last,
                         task_answer_packet_size_in_bytes);
  modport slave  (input  task_manager_ready,
                  output task_answer_ready, task_answer_data, task_answer_data_last,
                         task_answer_packet_size_in_bytes);
endinterface

// File: rtl/task_manager_byte_buf.sv
// Simple dual-port packet buffer: synchronous write, registered read.
// The registered read provides the one-cycle request-to-valid latency.
module task_manager_byte_buf
  import task_manager_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [TASK_BYTE_W-1:0] wdata,
  input  logic                   re,
  input  logic [AW-1:0]          raddr,
  output logic [TASK_BYTE_W-1:0] rdata
);

  logic [TASK_BYTE_W-1:0] mem [DEPTH];

  // NOTE: storage and read register have no reset so the array maps onto block RAM;
  // consumers gate rdata with their own valid flag.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/task_manager.sv
// Host-side task manager: buffers one host packet, streams it into a task, returns its answer.
// Optional answer watchdog enabled by defining TASK_MANAGER_TIMEOUT_EN.
module task_manager
  import task_manager_pkg::*;
#(
  parameter int NUM_BYTES_IN   = 256,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_pkt_valid,
  input  logic [TASK_BYTE_W-1:0] i_pkt_byte,
  input  logic                   i_pkt_last,
  output logic                   o_pkt_ready,
  task_in_interface.master       tim,
  task_out_interface.master      tom,
  output logic                   o_res_valid,
  output logic [TASK_WORD_W-1:0] o_res_data,
  output logic                   o_res_last,
  output logic                   o_done,
  output logic                   o_err_size,
  output logic                   o_err_ovf,
  output logic                   o_err_timeout
);

  localparam int AW = $clog2(NUM_BYTES_IN);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH = PW'(NUM_BYTES_IN);

  tm_state_t              state_q, state_d;
  logic [PW-1:0]          wp_q, wp_d, rp_q, rp_d, len_q, len_d;
  logic [TASK_SIZE_W-1:0] size_q, size_d;
  logic [10:0]            wcnt_q, wcnt_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                   res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic [TASK_WORD_W-1:0] res_data_q, res_data_d;
  logic                   done_q, done_d;
  logic                   err_size_q, err_size_d, err_ovf_q, err_ovf_d;

  logic                   ram_we, ram_re;
  logic [AW-1:0]          ram_waddr, ram_raddr;
  logic [TASK_BYTE_W-1:0] ram_rdata;

`ifdef TASK_MANAGER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_tmo_q, err_tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  task_manager_byte_buf #(.DEPTH(NUM_BYTES_IN), .AW(AW)) u_buf (
    .clk  (i_clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(i_pkt_byte),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // NOTE: every variable gets a default before the case so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    len_d       = len_q;
    size_d      = size_q;
    wcnt_d      = wcnt_q;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    res_valid_d = 1'b0;
    res_last_d  = 1'b0;
    res_data_d  = '0;
    done_d      = 1'b0;
    err_size_d  = err_size_q;
    err_ovf_d   = err_ovf_q;
    ram_we      = 1'b0;
    ram_waddr   = wp_q[AW-1:0];
    ram_re      = 1'b0;
    ram_raddr   = rp_q[AW-1:0];
`ifdef TASK_MANAGER_TIMEOUT_EN
    tmo_d       = '0;
    err_tmo_d   = err_tmo_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (i_pkt_valid) begin
          ram_we     = 1'b1;
          ram_waddr  = '0;
          wp_d       = PW'(1);
          rp_d       = '0;
          wcnt_d     = '0;
          size_d     = '0;
          err_size_d = 1'b0;
          err_ovf_d  = 1'b0;
`ifdef TASK_MANAGER_TIMEOUT_EN
          err_tmo_d  = 1'b0;
`endif
          // A single-byte packet carries its last flag on the opening byte.
          if (i_pkt_last) begin
            len_d   = PW'(1);
            state_d = ST_SEND;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (i_pkt_valid) begin
          if (wp_q < DEPTH) begin
            ram_we = 1'b1;
            wp_d   = wp_q + PW'(1);
          end else begin
            err_ovf_d = 1'b1;
          end
          if (i_pkt_last) begin
            len_d   = (wp_q < DEPTH) ? wp_q + PW'(1) : DEPTH;
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (tim.task_data_request && (rp_q < len_q)) begin
          ram_re   = 1'b1;
          tvalid_d = 1'b1;
          tlast_d  = (rp_q == len_q - PW'(1));
          rp_d     = rp_q + PW'(1);
          if (tlast_d) state_d = ST_WAIT_ANS;
        end
      end
      ST_WAIT_ANS: begin
        if (tom.task_answer_ready) begin
          size_d  = tom.task_answer_packet_size_in_bytes;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (tom.task_answer_ready) begin
          res_valid_d = 1'b1;
          res_data_d  = tom.task_answer_data;
          wcnt_d      = wcnt_q + 11'd1;
          if (tom.task_answer_data_last) begin
            res_last_d = 1'b1;
            state_d    = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_d     = 1'b1;
        err_size_d = ({2'b00, wcnt_q} != ceil_words(size_q));
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TASK_MANAGER_TIMEOUT_EN
    // Watchdog restarts on every answer handshake; on expiry the answer is abandoned.
    if ((state_q == ST_WAIT_ANS) || (state_q == ST_RECV)) begin
      if (tom.task_answer_ready) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        err_tmo_d = 1'b1;
        state_d   = ST_DONE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      len_q       <= '0;
      size_q      <= '0;
      wcnt_q      <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
      err_size_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
`ifdef TASK_MANAGER_TIMEOUT_EN
      tmo_q       <= '0;
      err_tmo_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      len_q       <= len_d;
      size_q      <= size_d;
      wcnt_q      <= wcnt_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
      err_size_q  <= err_size_d;
      err_ovf_q   <= err_ovf_d;
`ifdef TASK_MANAGER_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_tmo_q   <= err_tmo_d;
`endif
    end
  end

  assign o_pkt_ready            = (state_q == ST_LOAD);
  assign tim.task_data          = tvalid_q ? ram_rdata : '0;
  assign tim.task_data_valid    = tvalid_q;
  assign tim.task_data_last     = tlast_q;
  assign tom.task_manager_ready = (state_q == ST_RECV);
  assign o_res_valid            = res_valid_q;
  assign o_res_data             = res_data_q;
  assign o_res_last             = res_last_q;
  assign o_done                 = done_q;
  assign o_err_size             = err_size_q;
  assign o_err_ovf              = err_ovf_q;
`ifdef TASK_MANAGER_TIMEOUT_EN
  assign o_err_timeout          = err_tmo_q;
`else
  assign o_err_timeout          = 1'b0;
`endif

endmodule
